sync_fifo_flags: RTL

Single-clock, parametrised FIFO with registered read data. It adds usable full depth, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It sits between producer and consumer pipeline stages in the datapath and is the drop-in successor to the plain FIFO used there.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_mem.sv | 31 +++
 rtl/sync_fifo_flags.sv | 109 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter legality check for the flagged FIFO.
// Optional high-water-mark port is enabled with SYNC_FIFO_HWM_EN.
package fifo_pkg;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit params_ok(input int depth, input int af, input int ae);
      return (depth >= 2) && ((depth & (depth - 1)) == 0)
          && (ae < af) && (af <= depth);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port and one
// registered read port whose output register resets to zero.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 16,
   localparam int ADDR_W    = addr_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy, almost/full/empty, sticky error flags
// and flush. Define SYNC_FIFO_HWM_EN to add the hwm high-water-mark port.
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 1,
   localparam int ADDR_W    = addr_w(DEPTH),
   localparam int CNT_W     = cnt_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  w_en,
   input  logic                  r_en,
   input  logic                  flush,
   input  logic                  clr_err,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
`ifdef SYNC_FIFO_HWM_EN
   ,
   output logic [CNT_W-1:0]      hwm
`endif
);

   if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $error("sync_fifo_flags: illegal DEPTH/AF_THRESH/AE_THRESH");
   end

   localparam logic [CNT_W-1:0] AF_T = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_T = CNT_W'(AE_THRESH);

   logic [CNT_W-1:0] w_ptr;
   logic [CNT_W-1:0] r_ptr;
   logic             wr_acc;
   logic             rd_acc;

   // Extra wrap bit distinguishes full from empty when low bits match.
   assign empty = (w_ptr == r_ptr);
   assign full  = (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0])
               && (w_ptr[ADDR_W] != r_ptr[ADDR_W]);
   assign count        = w_ptr - r_ptr;
   assign almost_full  = (count >= AF_T);
   assign almost_empty = (count <= AE_T);

   assign wr_acc = w_en && !full  && !flush;
   assign rd_acc = r_en && !empty && !flush;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         out_valid <= 1'b0;
      end else if (flush) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (wr_acc) w_ptr <= w_ptr + 1'b1;
         if (rd_acc) r_ptr <= r_ptr + 1'b1;
         out_valid <= rd_acc;
      end
   end

   // A new error in the same cycle as clr_err wins, so it is never lost.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_en && full && !flush) overflow <= 1'b1;
         else if (clr_err)           overflow <= 1'b0;
         if (r_en && empty && !flush) underflow <= 1'b1;
         else if (clr_err)            underflow <= 1'b0;
      end
   end

`ifdef SYNC_FIFO_HWM_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)            hwm <= '0;
      else if (flush)       hwm <= '0;
      else if (count > hwm) hwm <= count;
   end
`endif

   fifo_mem #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem (
      .clk   (clk),
      .rstn  (rstn),
      .we    (wr_acc),
      .waddr (w_ptr[ADDR_W-1:0]),
      .wdata (in_data),
      .re    (rd_acc),
      .raddr (r_ptr[ADDR_W-1:0]),
      .rdata (out_data)
   );

endmodule
